xsim_msg_bridge: RTL and testbench

//  Parametrised simulation-side bridge between host/testbench logic and a DUT's msgSource/msgSink beat ports.

---
 rtl/xsim_msg_pkg.sv | 14 +
 rtl/msg_beat_fifo.sv | 79 +++++++
 rtl/xsim_msg_bridge.sv | 148 ++++++++++++++
 tb/tb_xsim_msg_bridge.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xsim_msg_pkg.sv
// Shared types and default sizing for the xsim message bridge.
package xsim_msg_pkg;

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int DEF_NUM_CH   = 1;
  localparam int DEF_BEAT_W   = 32;
  localparam int DEF_DEPTH    = 8;
  localparam int DEF_RST_HOLD = 10;

endpackage

// File: rtl/msg_beat_fifo.sv
// Beat FIFO with register-array storage and a registered head: push visible on dout next cycle.
// Push while full is accepted only when a pop drains the same edge; pop while empty is ignored.
module msg_beat_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_head;

  logic             w_do_pop;
  logic             w_do_push;
  logic [AW-1:0]    w_rd_next;
  logic [WIDTH-1:0] w_head_next;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign w_rd_next = r_rd_ptr + 1'b1;
  assign dout      = r_head;

  // Head tracks the next entry so dout never needs a combinational array read.
  always_comb begin
    w_head_next = r_head;
    if (w_do_pop) begin
      if (r_count == (AW+1)'(1)) begin
        w_head_next = w_do_push ? din : '0;
      end else begin
        w_head_next = r_mem[w_rd_next];
      end
    end else if (empty && w_do_push) begin
      w_head_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      r_head <= w_head_next;
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/xsim_msg_bridge.sv
// Host<->DUT beat bridge with DUT reset sequencing; rx/tx data appear one cycle after transfer.
// Ready outputs derive from registered FIFO state only. XSIM_MSG_STATS_EN adds per-channel transfer counters.
module xsim_msg_bridge
  import xsim_msg_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int BEAT_W   = DEF_BEAT_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int RST_HOLD = DEF_RST_HOLD
) (
  input  logic                     CLK,
  input  logic                     RST,
  output logic                     dut_rst_n,
  output logic                     rst_done,
  input  logic [NUM_CH-1:0]        msgSource_src_rdy,
  input  logic [NUM_CH*BEAT_W-1:0] msgSource_beat,
  output logic [NUM_CH-1:0]        msgSource_dst_rdy_b,
  output logic [NUM_CH-1:0]        msgSink_src_rdy_b,
  output logic [NUM_CH*BEAT_W-1:0] msgSink_beat_v,
  input  logic [NUM_CH-1:0]        msgSink_dst_rdy,
  output logic [NUM_CH-1:0]        rx_valid,
  output logic [NUM_CH*BEAT_W-1:0] rx_data,
  input  logic [NUM_CH-1:0]        rx_pop,
  input  logic [NUM_CH-1:0]        tx_push,
  input  logic [NUM_CH*BEAT_W-1:0] tx_data,
  output logic [NUM_CH-1:0]        tx_full,
  output logic [NUM_CH-1:0]        err_ovf
`ifdef XSIM_MSG_STATS_EN
  ,
  output logic [NUM_CH*32-1:0]     stat_rx_cnt,
  output logic [NUM_CH*32-1:0]     stat_tx_cnt
`endif
);

  localparam int CW = $clog2(RST_HOLD) + 1;

  seq_state_e      r_state;
  seq_state_e      w_state_next;
  logic [CW-1:0]   r_cnt;

  logic [NUM_CH-1:0] w_src_fire;
  logic [NUM_CH-1:0] w_sink_fire;
  logic [NUM_CH-1:0] w_err_set;
  logic [NUM_CH-1:0] r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= HOLD;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == HOLD) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HOLD:    if (r_cnt == CW'(RST_HOLD - 1)) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = HOLD;
    endcase
  end

  always_comb begin
    dut_rst_n = 1'b0;
    rst_done  = 1'b0;
    if (r_state == RUN) begin
      dut_rst_n = 1'b1;
      rst_done  = 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_rx_empty;
    logic w_rx_full;
    logic w_tx_empty;

    assign w_src_fire[c]  = msgSource_src_rdy[c] & msgSource_dst_rdy_b[c];
    assign w_sink_fire[c] = msgSink_src_rdy_b[c] & msgSink_dst_rdy[c];

    msg_beat_fifo #(.WIDTH(BEAT_W), .DEPTH(DEPTH)) u_rx_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (w_src_fire[c]),
      .pop   (rx_pop[c]),
      .din   (msgSource_beat[c*BEAT_W +: BEAT_W]),
      .dout  (rx_data[c*BEAT_W +: BEAT_W]),
      .empty (w_rx_empty),
      .full  (w_rx_full)
    );

    msg_beat_fifo #(.WIDTH(BEAT_W), .DEPTH(DEPTH)) u_tx_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (tx_push[c]),
      .pop   (w_sink_fire[c]),
      .din   (tx_data[c*BEAT_W +: BEAT_W]),
      .dout  (msgSink_beat_v[c*BEAT_W +: BEAT_W]),
      .empty (w_tx_empty),
      .full  (tx_full[c])
    );

    assign rx_valid[c]            = ~w_rx_empty;
    assign msgSource_dst_rdy_b[c] = rst_done & ~w_rx_full;
    assign msgSink_src_rdy_b[c]   = rst_done & ~w_tx_empty;
    // A full tx FIFO draining on the same edge still takes the push.
    assign w_err_set[c] = (tx_push[c] & tx_full[c] & ~w_sink_fire[c]) |
                          (rx_pop[c] & w_rx_empty);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err <= '0;
    end else begin
      r_err <= r_err | w_err_set;
    end
  end

  assign err_ovf = r_err;

`ifdef XSIM_MSG_STATS_EN
  logic [31:0] r_stat_rx [NUM_CH];
  logic [31:0] r_stat_tx [NUM_CH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_stat_rx[c] <= '0;
        r_stat_tx[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_src_fire[c])  r_stat_rx[c] <= r_stat_rx[c] + 32'd1;
        if (w_sink_fire[c]) r_stat_tx[c] <= r_stat_tx[c] + 32'd1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_stat
    assign stat_rx_cnt[c*32 +: 32] = r_stat_rx[c];
    assign stat_tx_cnt[c*32 +: 32] = r_stat_tx[c];
  end
`endif

endmodule

// File: tb/tb_xsim_msg_bridge.sv
// Randomised scoreboard bench for xsim_msg_bridge: queue-based reference model checked every cycle.
module tb_xsim_msg_bridge;

  localparam int NC = 2;
  localparam int BW = 16;
  localparam int DP = 4;
  localparam int RH = 10;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             dut_rst_n, rst_done;
  logic [NC-1:0]    msgSource_src_rdy;
  logic [NC*BW-1:0] msgSource_beat;
  logic [NC-1:0]    msgSource_dst_rdy_b;
  logic [NC-1:0]    msgSink_src_rdy_b;
  logic [NC*BW-1:0] msgSink_beat_v;
  logic [NC-1:0]    msgSink_dst_rdy;
  logic [NC-1:0]    rx_valid;
  logic [NC*BW-1:0] rx_data;
  logic [NC-1:0]    rx_pop;
  logic [NC-1:0]    tx_push;
  logic [NC*BW-1:0] tx_data;
  logic [NC-1:0]    tx_full;
  logic [NC-1:0]    err_ovf;
`ifdef XSIM_MSG_STATS_EN
  logic [NC*32-1:0] stat_rx_cnt, stat_tx_cnt;
`endif

  xsim_msg_bridge #(.NUM_CH(NC), .BEAT_W(BW), .DEPTH(DP), .RST_HOLD(RH)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .dut_rst_n           (dut_rst_n),
    .rst_done            (rst_done),
    .msgSource_src_rdy   (msgSource_src_rdy),
    .msgSource_beat      (msgSource_beat),
    .msgSource_dst_rdy_b (msgSource_dst_rdy_b),
    .msgSink_src_rdy_b   (msgSink_src_rdy_b),
    .msgSink_beat_v      (msgSink_beat_v),
    .msgSink_dst_rdy     (msgSink_dst_rdy),
    .rx_valid            (rx_valid),
    .rx_data             (rx_data),
    .rx_pop              (rx_pop),
    .tx_push             (tx_push),
    .tx_data             (tx_data),
    .tx_full             (tx_full),
    .err_ovf             (err_ovf)
`ifdef XSIM_MSG_STATS_EN
    ,
    .stat_rx_cnt         (stat_rx_cnt),
    .stat_tx_cnt         (stat_tx_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues per channel plus an edge count since reset release.
  logic [BW-1:0] rxq [NC][$];
  logic [BW-1:0] txq [NC][$];
  bit            err_m [NC];
  int            rxn [NC];
  int            txn [NC];
  int            edges;
  bit            run_m;
  bit            s_fire, k_fire;

  always @(posedge CLK or posedge RST) begin
    if (RST) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(negedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NC; c++) begin
        rxq[c].delete();
        txq[c].delete();
        err_m[c] = 1'b0;
        rxn[c]   = 0;
        txn[c]   = 0;
      end
    end else begin
      run_m = (edges >= RH);
      chk("dut_rst_n", 64'(dut_rst_n), 64'(run_m));
      chk("rst_done", 64'(rst_done), 64'(run_m));
      for (int c = 0; c < NC; c++) begin
        chk("rx_valid", 64'(rx_valid[c]), 64'(rxq[c].size() > 0));
        if (rxq[c].size() > 0) chk("rx_data", 64'(rx_data[c*BW +: BW]), 64'(rxq[c][0]));
        chk("dst_rdy_b", 64'(msgSource_dst_rdy_b[c]), 64'(run_m && rxq[c].size() < DP));
        chk("tx_full", 64'(tx_full[c]), 64'(txq[c].size() == DP));
        chk("src_rdy_b", 64'(msgSink_src_rdy_b[c]), 64'(run_m && txq[c].size() > 0));
        chk("beat_v", 64'(msgSink_beat_v[c*BW +: BW]),
            (txq[c].size() > 0) ? 64'(txq[c][0]) : 64'd0);
        chk("err_ovf", 64'(err_ovf[c]), 64'(err_m[c]));
`ifdef XSIM_MSG_STATS_EN
        chk("stat_rx_cnt", 64'(stat_rx_cnt[c*32 +: 32]), 64'(rxn[c]));
        chk("stat_tx_cnt", 64'(stat_tx_cnt[c*32 +: 32]), 64'(txn[c]));
`endif
        // Advance the model by the coming edge, using pre-edge occupancy for readiness.
        s_fire = msgSource_src_rdy[c] && run_m && (rxq[c].size() < DP);
        if (rx_pop[c]) begin
          if (rxq[c].size() > 0) void'(rxq[c].pop_front());
          else                   err_m[c] = 1'b1;
        end
        if (s_fire) begin
          rxq[c].push_back(msgSource_beat[c*BW +: BW]);
          rxn[c]++;
        end
        k_fire = run_m && (txq[c].size() > 0) && msgSink_dst_rdy[c];
        if (k_fire) begin
          void'(txq[c].pop_front());
          txn[c]++;
        end
        if (tx_push[c]) begin
          if (txq[c].size() < DP) txq[c].push_back(tx_data[c*BW +: BW]);
          else                    err_m[c] = 1'b1;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dut_rst_n"}, 64'(dut_rst_n), 64'd0);
    chk({tag, "_rst_done"}, 64'(rst_done), 64'd0);
    chk({tag, "_dst_rdy_b"}, 64'(msgSource_dst_rdy_b), 64'd0);
    chk({tag, "_src_rdy_b"}, 64'(msgSink_src_rdy_b), 64'd0);
    chk({tag, "_beat_v"}, 64'(msgSink_beat_v), 64'd0);
    chk({tag, "_rx_valid"}, 64'(rx_valid), 64'd0);
    chk({tag, "_rx_data"}, 64'(rx_data), 64'd0);
    chk({tag, "_tx_full"}, 64'(tx_full), 64'd0);
    chk({tag, "_err_ovf"}, 64'(err_ovf), 64'd0);
  endtask

  task automatic rand_phase(input int n);
    for (int i = 0; i < n; i++) begin
      msgSource_src_rdy = NC'($urandom_range(0, 3));
      msgSource_beat    = $urandom;
      msgSink_dst_rdy   = NC'($urandom_range(0, 3));
      rx_pop            = NC'($urandom_range(0, 3)) & NC'($urandom_range(0, 3));
      tx_push           = NC'($urandom_range(0, 3));
      tx_data           = $urandom;
      cyc(1);
    end
    msgSource_src_rdy = '0;
    rx_pop            = '0;
    tx_push           = '0;
  endtask

  int n;

  initial begin
    msgSource_src_rdy = '0;
    msgSource_beat    = '0;
    msgSink_dst_rdy   = '0;
    rx_pop            = '0;
    tx_push           = '0;
    tx_data           = '0;
    cyc(3);
    check_zero("reset");

    // Release reset; queue two beats during the hold window.
    RST             = 1'b0;
    msgSink_dst_rdy = 2'b11;
    tx_push         = 2'b01;
    tx_data         = 32'h0000_00A5;
    n = 0;
    while (!rst_done && n < 50) begin
      cyc(1);
      n++;
      if (n == 1) tx_data = 32'h0000_005A;
      if (n == 2) tx_push = '0;
    end
    chk("rst_hold_edges", 64'(n), 64'(RH));
    cyc(4);

    // ch1 stream with no pops; ch0 idle.
    for (int i = 0; i < 3; i++) begin
      msgSource_src_rdy = 2'b10;
      msgSource_beat    = {16'(8'h11 * (i + 1)), 16'h0};
      cyc(1);
    end
    msgSource_src_rdy = '0;
    cyc(2);

    rand_phase(1500);

    // Drain everything, then fill rx ch0 and tx ch0 to capacity.
    msgSink_dst_rdy = 2'b11;
    rx_pop          = 2'b11;
    cyc(8);
    rx_pop          = '0;
    msgSink_dst_rdy = '0;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      msgSource_src_rdy = 2'b01;
      msgSource_beat    = 32'(16'h100 + i);
      tx_push           = 2'b01;
      tx_data           = (i == 4) ? 32'h0000_00FF : 32'(16'h200 + i);
      cyc(1);
    end
    tx_push = '0;
    cyc(1);
    chk("tx_full_after_fill", 64'(tx_full[0]), 64'd1);
    chk("dst_rdy_b_full", 64'(msgSource_dst_rdy_b[0]), 64'd0);
    rx_pop = 2'b01;
    cyc(1);
    rx_pop = '0;
    cyc(2);
    msgSource_src_rdy = '0;
    cyc(1);

    // Asynchronous reset mid-stream.
    msgSink_dst_rdy = 2'b11;
    #2;
    RST = 1'b1;
    #1;
    check_zero("midrst");
    cyc(2);
    RST = 1'b0;
    cyc(RH + 2);
    rand_phase(600);
    cyc(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
